mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write) in the multi-cycle npc core.
- Sits between the IFU/LSU requesters and the memory/DPI bridge.
- Allows exactly one outstanding transaction, run by a 3-state FSM.
- Routes each response back to the requester that owns the transaction.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  fetched word
- lsu_req_valid  in  1  LSU request pending
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  load data / store ack valid (1-cycle pulse)
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered strobes
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states:
  - IDLE: no transaction in flight.
  - REQ: mem_req_valid=1; wait for mem_req_ready.
  - WAIT: wait for mem_resp_valid.
- IDLE arbitration, default mode:
  - Fixed priority, LSU over IFU.
  - lsu_req_ready = lsu_req_valid.
  - ifu_req_ready = ifu_req_valid & ~lsu_req_valid.
  - Ready is combinational, only ever asserted in IDLE, and never asserted for both requesters in the same cycle.
- Accept, on valid&ready in IDLE:
  - Register addr/wen/wdata/wmask into the mem_* outputs; owner <= granted requester.
  - State -> REQ next cycle.
  - IFU requests register wen=0, wdata=0, wmask=0.
- REQ: on mem_req_ready, state -> WAIT. mem_* outputs stay stable while in REQ.
- WAIT: on mem_resp_valid:
  - Assert the owner's resp_valid combinationally in the same cycle; its rdata = mem_rdata.
  - State -> IDLE.
- Non-owner resp_valid is always 0, and its rdata is 0.
- Stores get an ack pulse; lsu_rdata on a store ack = mem_rdata and is don't-care to the LSU.
- Minimum transaction cost: accept cycle, REQ cycle, response cycle. The next accept happens in IDLE the cycle after the response. No back-to-back grants.
- mem_resp_valid outside WAIT (IDLE or REQ, including the same cycle as mem_req_ready) is ignored. Memory must respond at least 1 cycle after accept.
- Requesters must hold valid and payload until ready. Dropping valid before ready is legal and simply loses arbitration.
- rst (any state, including mid-REQ/WAIT):
  - State -> IDLE; owner <= IFU; last_grant <= IFU.
  - mem_req_valid=0; mem_addr/wdata/wmask=0; mem_wen=0.
  - All resp_valid=0, all ready=0 during the rst cycle, busy=0.
  - The in-flight transaction is dropped; a late response after reset is ignored.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - last_grant register updates on each accept.
  - When both requesters are valid in IDLE, grant the one not equal to last_grant.
  - After reset last_grant=IFU, so the first contended grant goes to LSU.
  - A single valid requester is always granted.
- Undefined: fixed LSU priority as above; no last_grant register is synthesised.

Test Plan:
- Reset, then IFU read: ifu_req_valid=1, ifu_addr=0x80000000, mem_req_ready=1 at once, mem_resp_valid=1 one cycle after REQ with mem_rdata=0x00000413 -> mem_addr=0x80000000, mem_wen=0; ifu_resp_valid pulses 1 cycle with ifu_rdata=0x00000413; lsu_resp_valid stays 0; busy high for 2 cycles.
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, wen=1; mem_req_ready held 0 for 3 cycles -> mem_* stable throughout REQ; ack appears on lsu_resp_valid only.
- Contention: both valid in the same IDLE cycle -> default build grants LSU, IFU granted in the IDLE after the LSU response. With MEM_PORT_ARB_RR_EN and both held valid for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
- Stray response: mem_resp_valid=1 while IDLE and in the same cycle as mem_req_ready -> no resp_valid pulse, state unaffected.
- Reset mid-WAIT: assert rst during WAIT, then mem_resp_valid 2 cycles later -> busy=0 and mem_req_valid=0 after the rst cycle; no resp_valid pulse; the next IFU request proceeds normally.
- Requester drops valid: ifu_req_valid=1 for 1 cycle while lsu_req_valid=1 -> LSU served; no IFU transaction occurs.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU/LSU request, response and memory-side signals of the shared port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [STRB_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output busy
  );

  // Requesters plus memory, as seen from outside the arbiter
  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IFU/LSU arbiter for the shared memory port
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_lsu_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wmask_q;

  logic              grant_lsu, grant_ifu;
  logic              accept;
  logic              ifu_ready, lsu_ready;
  logic              ifu_resp, lsu_resp;
  logic [DATA_W-1:0] ifu_rdata, lsu_rdata;
  logic              req_valid, busy;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_grant_lsu_q;

  // Under contention, hand the port to whoever did not win last time
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
    grant_ifu = bus.ifu_req_valid & ~bus.lsu_req_valid;
    if (bus.lsu_req_valid && bus.ifu_req_valid) begin
      grant_lsu = ~last_grant_lsu_q;
      grant_ifu = last_grant_lsu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_lsu_q <= 1'b0;
    end else if (accept) begin
      last_grant_lsu_q <= grant_lsu;
    end
  end
`else
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
    grant_ifu = bus.ifu_req_valid & ~bus.lsu_req_valid;
  end
`endif

  assign accept = (state_q == S_IDLE) & ~rst & (grant_lsu | grant_ifu);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Responses arriving outside WAIT are dropped by construction
  always_comb begin
    state_d   = state_q;
    ifu_ready = 1'b0;
    lsu_ready = 1'b0;
    ifu_resp  = 1'b0;
    lsu_resp  = 1'b0;
    ifu_rdata = '0;
    lsu_rdata = '0;
    req_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ifu_ready = grant_ifu & ~rst;
        lsu_ready = grant_lsu & ~rst;
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        req_valid = ~rst;
        busy      = ~rst;
        if (bus.mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy = ~rst;
        if (bus.mem_resp_valid) begin
          state_d = S_IDLE;
          if (!rst) begin
            if (owner_lsu_q) begin
              lsu_resp  = 1'b1;
              lsu_rdata = bus.mem_rdata;
            end else begin
              ifu_resp  = 1'b1;
              ifu_rdata = bus.mem_rdata;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetches carry no write payload, so their wen/wdata/wmask are zeroed
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsu_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else if (accept) begin
      owner_lsu_q <= grant_lsu;
      mem_addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
      mem_wen_q   <= grant_lsu & bus.lsu_wen;
      mem_wdata_q <= grant_lsu ? bus.lsu_wdata : '0;
      mem_wmask_q <= grant_lsu ? bus.lsu_wmask : '0;
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_resp;
  assign bus.lsu_resp_valid = lsu_resp;
  assign bus.ifu_rdata      = ifu_rdata;
  assign bus.lsu_rdata      = lsu_rdata;
  assign bus.mem_req_valid  = req_valid;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wmask      = mem_wmask_q;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    tick();
    settle();
    total++; if (bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ifu_ready got=%0h exp=0", bus.ifu_req_ready); end
    total++; if (bus.lsu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_lsu_ready got=%0h exp=0", bus.lsu_req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid got=%0h exp=0", bus.mem_req_valid); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wen !== 1'b0) begin bad++; $display("FAIL rst_mem_wen got=%0h exp=0", bus.mem_wen); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); end
    total++; if (bus.mem_wmask !== 4'h0) begin bad++; $display("FAIL rst_mem_wmask got=%0h exp=0", bus.mem_wmask); end
    total++; if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%0h%0h exp=00", bus.ifu_resp_valid, bus.lsu_resp_valid); end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    settle();
    total++; if (bus.ifu_req_ready !== 1'b1) begin bad++; $display("FAIL ifu_ready got=%0h exp=1", bus.ifu_req_ready); end
    total++; if (bus.lsu_req_ready !== 1'b0) begin bad++; $display("FAIL ifu_lsu_ready got=%0h exp=0", bus.lsu_req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ifu_busy_idle got=%0h exp=0", bus.busy); end
    tick();
    bus.ifu_req_valid = 1'b0;
    settle();
    total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL ifu_mem_req_valid got=%0h exp=1", bus.mem_req_valid); end
    total++; if (bus.mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL ifu_mem_addr got=%0h exp=80000000", bus.mem_addr); end
    total++; if (bus.mem_wen !== 1'b0 || bus.mem_wmask !== 4'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL ifu_mem_wr got=%0h/%0h/%0h exp=0/0/0", bus.mem_wen, bus.mem_wmask, bus.mem_wdata); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ifu_busy_req got=%0h exp=1", bus.busy); end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0413;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b1) begin bad++; $display("FAIL ifu_resp_valid got=%0h exp=1", bus.ifu_resp_valid); end
    total++; if (bus.ifu_rdata !== 32'h0000_0413) begin bad++; $display("FAIL ifu_rdata got=%0h exp=413", bus.ifu_rdata); end
    total++; if (bus.lsu_resp_valid !== 1'b0 || bus.lsu_rdata !== 32'h0) begin bad++; $display("FAIL ifu_lsu_quiet got=%0h/%0h exp=0/0", bus.lsu_resp_valid, bus.lsu_rdata); end
    total++; if (bus.busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL ifu_wait got=busy%0h/req%0h exp=1/0", bus.busy, bus.mem_req_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin bad++; $display("FAIL ifu_done got=busy%0h/resp%0h exp=0/0", bus.busy, bus.ifu_resp_valid); end
  endtask

  task automatic test_lsu_store();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'hF;
    bus.mem_req_ready = 1'b0;
    settle();
    total++; if (bus.lsu_req_ready !== 1'b1 || bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL st_ready got=lsu%0h/ifu%0h exp=1/0", bus.lsu_req_ready, bus.ifu_req_ready); end
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h1111_2222;
    bus.lsu_wdata     = 32'h3333_4444;
    bus.lsu_wmask     = 4'h1;
    bus.lsu_wen       = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.mem_req_ready = 1'b1;
      settle();
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_1000 || bus.mem_wen !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'hF) begin
        bad++; $display("FAIL st_req_stable c=%0d got=%0h/%0h/%0h/%0h/%0h exp=1/80001000/1/deadbeef/f", c, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    settle();
    total++; if (bus.lsu_resp_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL st_wait got=resp%0h/busy%0h exp=0/1", bus.lsu_resp_valid, bus.busy); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    settle();
    total++; if (bus.lsu_resp_valid !== 1'b1 || bus.lsu_rdata !== 32'h1234_5678) begin bad++; $display("FAIL st_ack got=%0h/%0h exp=1/12345678", bus.lsu_resp_valid, bus.lsu_rdata); end
    total++; if (bus.ifu_resp_valid !== 1'b0 || bus.ifu_rdata !== 32'h0) begin bad++; $display("FAIL st_ifu_quiet got=%0h/%0h exp=0/0", bus.ifu_resp_valid, bus.ifu_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL st_done got=busy%0h/resp%0h exp=0/0", bus.busy, bus.lsu_resp_valid); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_lsu;
    int         n;
    logic       drop;
    logic       el;
`ifdef MEM_PORT_ARB_RR_EN
    n = 4; exp_lsu = 4'b0101; drop = 1'b0;
`else
    n = 2; exp_lsu = 4'b0001; drop = 1'b1;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0200;
    bus.lsu_wen       = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      el = exp_lsu[k];
      settle();
      total++; if (bus.lsu_req_ready !== el || bus.ifu_req_ready !== ~el) begin bad++; $display("FAIL ct_grant k=%0d got=lsu%0h/ifu%0h exp=%0h/%0h", k, bus.lsu_req_ready, bus.ifu_req_ready, el, ~el); end
      tick();
      if (drop && k == 0) bus.lsu_req_valid = 1'b0;
      settle();
      total++; if (bus.mem_addr !== (el ? 32'h0000_0200 : 32'h0000_0100)) begin bad++; $display("FAIL ct_addr k=%0d got=%0h exp=%0h", k, bus.mem_addr, (el ? 32'h200 : 32'h100)); end
      total++; if (bus.lsu_req_ready !== 1'b0 || bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL ct_no_ready_req k=%0d got=%0h/%0h exp=0/0", k, bus.lsu_req_ready, bus.ifu_req_ready); end
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'(k + 1);
      settle();
      total++; if (bus.lsu_resp_valid !== el || bus.ifu_resp_valid !== ~el) begin bad++; $display("FAIL ct_resp k=%0d got=lsu%0h/ifu%0h exp=%0h/%0h", k, bus.lsu_resp_valid, bus.ifu_resp_valid, el, ~el); end
      tick();
      bus.mem_resp_valid = 1'b0;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic test_stray_resp();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_0001;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL sr_idle_resp got=%0h/%0h exp=0/0", bus.ifu_resp_valid, bus.lsu_resp_valid); end
    tick();
    settle();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sr_idle_state got=%0h exp=0", bus.busy); end
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0300;
    settle();
    total++; if (bus.ifu_req_ready !== 1'b1 || bus.ifu_resp_valid !== 1'b0) begin bad++; $display("FAIL sr_accept got=rdy%0h/resp%0h exp=1/0", bus.ifu_req_ready, bus.ifu_resp_valid); end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL sr_req_resp got=%0h/%0h/busy%0h exp=0/0/1", bus.ifu_resp_valid, bus.lsu_resp_valid, bus.busy); end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b1 || bus.ifu_resp_valid !== 1'b0) begin bad++; $display("FAIL sr_wait got=busy%0h/resp%0h exp=1/0", bus.busy, bus.ifu_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_00AA;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'h0000_00AA) begin bad++; $display("FAIL sr_real_resp got=%0h/%0h exp=1/aa", bus.ifu_resp_valid, bus.ifu_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sr_done got=%0h exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid_wait();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0400;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    settle();
    total++; if (bus.busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0 || bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL rw_rst_cycle got=busy%0h/resp%0h/rdy%0h exp=0/0/0", bus.busy, bus.ifu_resp_valid, bus.ifu_req_ready); end
    tick();
    rst = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rw_after got=busy%0h/req%0h/addr%0h exp=0/0/0", bus.busy, bus.mem_req_valid, bus.mem_addr); end
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_0002;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL rw_late_resp got=%0h/%0h exp=0/0", bus.ifu_resp_valid, bus.lsu_resp_valid); end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h0000_0500;
    settle();
    total++; if (bus.ifu_req_ready !== 1'b1) begin bad++; $display("FAIL rw_next_ready got=%0h exp=1", bus.ifu_req_ready); end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    total++; if (bus.mem_addr !== 32'h0000_0500 || bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL rw_next_req got=%0h/%0h exp=500/1", bus.mem_addr, bus.mem_req_valid); end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0055;
    settle();
    total++; if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'h0000_0055) begin bad++; $display("FAIL rw_next_resp got=%0h/%0h exp=1/55", bus.ifu_resp_valid, bus.ifu_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_drop_valid();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0700;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0600;
    bus.lsu_wen       = 1'b0;
    settle();
    total++; if (bus.lsu_req_ready !== 1'b1 || bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL dv_grant got=lsu%0h/ifu%0h exp=1/0", bus.lsu_req_ready, bus.ifu_req_ready); end
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    total++; if (bus.mem_addr !== 32'h0000_0600) begin bad++; $display("FAIL dv_addr got=%0h exp=600", bus.mem_addr); end
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0066;
    settle();
    total++; if (bus.lsu_resp_valid !== 1'b1 || bus.ifu_resp_valid !== 1'b0 || bus.lsu_rdata !== 32'h66) begin bad++; $display("FAIL dv_resp got=lsu%0h/ifu%0h/%0h exp=1/0/66", bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_rdata); end
    tick();
    bus.mem_resp_valid = 1'b0;
    settle();
    total++; if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL dv_idle got=busy%0h/req%0h exp=0/0", bus.busy, bus.mem_req_valid); end
    tick();
    settle();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL dv_no_ifu got=%0h exp=0", bus.busy); end
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    total = 0;
    bad   = 0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_contention();
    test_stray_resp();
    test_reset_mid_wait();
    test_drop_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
